// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction field geometry and opcode-class encoding shared by the CPU front end.
package cpu_pkg;
  localparam int OPCODE_W  = 6;
  localparam int IMM_W     = 9;
  localparam int INSTR_W   = 16;
  localparam int OPC_MSB   = 15;
  localparam int REGID_BIT = 9;
  typedef enum logic [1:0] {
    CLS_ALU    = 2'b00,
    CLS_MEM    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_SYS    = 2'b11
  } opc_cls_e;
endpackage

// File: rtl/instr_decoder_if.sv
// instr_decoder_if: fetch-to-decoder bus carrying the raw word and the decoded fields.
interface instr_decoder_if;
  import cpu_pkg::*;
  logic [INSTR_W-1:0]  instr;
  logic                in_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                regid;
  logic [IMM_W-1:0]    immed;
  logic                out_valid;
  logic [OPCODE_W-1:0] opcode_q;
  logic                regid_q;
  logic [IMM_W-1:0]    immed_q;
  logic [INSTR_W-1:0]  imm_sext;
  logic [INSTR_W-1:0]  imm_zext;
  logic                cls_alu;
  logic                cls_mem;
  logic                cls_branch;
  logic                cls_sys;
  modport master (
    output instr, in_valid,
    input  opcode, regid, immed, out_valid, opcode_q, regid_q, immed_q,
           imm_sext, imm_zext, cls_alu, cls_mem, cls_branch, cls_sys
  );
  modport slave (
    input  instr, in_valid,
    output opcode, regid, immed, out_valid, opcode_q, regid_q, immed_q,
           imm_sext, imm_zext, cls_alu, cls_mem, cls_branch, cls_sys
  );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: combinational field split plus a valid-qualified registered decode with extended immediates.
module instr_decoder
  import cpu_pkg::*;
(
  input logic             clk,
  input logic             rst,
  instr_decoder_if.slave  bus
);
  opc_cls_e cls;
  assign bus.opcode = bus.instr[OPC_MSB -: OPCODE_W];
  assign bus.regid  = bus.instr[REGID_BIT];
  assign bus.immed  = bus.instr[IMM_W-1:0];
  assign cls        = opc_cls_e'(bus.instr[OPC_MSB -: 2]);
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.opcode_q   <= '0;
      bus.regid_q    <= 1'b0;
      bus.immed_q    <= '0;
      bus.imm_sext   <= '0;
      bus.imm_zext   <= '0;
      bus.cls_alu    <= 1'b0;
      bus.cls_mem    <= 1'b0;
      bus.cls_branch <= 1'b0;
      bus.cls_sys    <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.opcode_q   <= bus.opcode;
        bus.regid_q    <= bus.regid;
        bus.immed_q    <= bus.immed;
        bus.imm_sext   <= {{(INSTR_W-IMM_W){bus.immed[IMM_W-1]}}, bus.immed};
        bus.imm_zext   <= {{(INSTR_W-IMM_W){1'b0}}, bus.immed};
        bus.cls_alu    <= cls == CLS_ALU;
        bus.cls_mem    <= cls == CLS_MEM;
        bus.cls_branch <= cls == CLS_BRANCH;
        bus.cls_sys    <= cls == CLS_SYS;
      end
    end
  end
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed plus randomized checks of instr_decoder against an arithmetic reference model.
module tb_instr_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit m_valid = 1'b0;
  bit m_loaded = 1'b0;
  int m_word = 0;
  instr_decoder_if bus();
  instr_decoder u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input int w, input bit v, input bit r);
    int im;
    int clsbits;
    @(negedge clk);
    bus.instr = w[15:0];
    bus.in_valid = v;
    rst = r;
    #1;
    chk("opcode", int'(bus.opcode), w / 1024);
    chk("regid", int'(bus.regid), (w / 512) % 2);
    chk("immed", int'(bus.immed), w % 512);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_loaded = 1'b0;
      m_word = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_loaded = 1'b1;
        m_word = w;
      end
    end
    #1;
    im = m_word % 512;
    clsbits = m_loaded ? (1 << (m_word / 16384)) : 0;
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("opcode_q", int'(bus.opcode_q), m_word / 1024);
    chk("regid_q", int'(bus.regid_q), (m_word / 512) % 2);
    chk("immed_q", int'(bus.immed_q), im);
    chk("imm_sext", int'(bus.imm_sext), im >= 256 ? im + 65536 - 512 : im);
    chk("imm_zext", int'(bus.imm_zext), im);
    chk("cls", int'({bus.cls_sys, bus.cls_branch, bus.cls_mem, bus.cls_alu}), clsbits);
  endtask
  initial begin
    bus.instr = '0;
    bus.in_valid = 1'b0;
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b1, 1'b0);
    step(16'hFFFF, 1'b1, 1'b0);
    step(16'h8001, 1'b1, 1'b0);
    step(16'h06FF, 1'b1, 1'b0);
    step(16'h0100, 1'b0, 1'b0);
    step(16'hFFFF, 1'b1, 1'b0);
    step(16'hFFFF, 1'b1, 1'b1);
    step(16'h4123, 1'b1, 1'b0);
    step(16'h8001, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_decoder.md
# instr_decoder

Single-cycle field decoder for the 16-bit CPU instruction word. It splits the word into opcode, register-select and 9-bit immediate fields, which are combinational. It also produces a registered, valid-qualified copy of the fields with sign- and zero-extended immediates and an opcode-class decode. It sits between the fetch stage and the execute/control logic.

## Interface
- Parameters: none. Instruction width is fixed at 16 bits.
- clk  input  1  single system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  16  instruction word.
- in_valid  input  1  instr carries a real instruction this cycle.
- opcode  output  6  combinational, instr[15:10].
- regid  output  1  combinational, instr[9] (register select, 0 = R0, 1 = R1).
- immed  output  9  combinational, instr[8:0].
- out_valid  output  1  registered in_valid.
- opcode_q  output  6  registered opcode.
- regid_q  output  1  registered regid.
- immed_q  output  9  registered immed.
- imm_sext  output  16  registered immed sign-extended from bit 8.
- imm_zext  output  16  registered immed zero-extended.
- cls_alu, cls_mem, cls_branch, cls_sys  output  1 each  registered one-hot class from opcode[5:4] (00, 01, 10, 11 respectively).

## Operation
- Field split is pure wiring, with no clock dependency: {opcode, regid, immed} == instr at all times, including during reset.
- On each rising clk edge with rst == 0:
  - out_valid <= in_valid.
  - When in_valid == 1, all *_q, imm_*, and cls_* outputs load from the current instr.
  - When in_valid == 0, those outputs hold their previous values.
- imm_sext = {{7{instr[8]}}, instr[8:0]}; imm_zext = {7'b0, instr[8:0]}.
- Exactly one cls_* bit is 1 whenever the registered word is loaded. After reset, all cls_* bits are 0.
- No illegal-opcode detection: every 6-bit opcode is accepted. Class is determined solely by opcode[5:4].

## Timing
- Combinational outputs: zero latency, settle within the same cycle as instr changes.
- Registered outputs: one-cycle latency. An instruction presented with in_valid at edge N appears on the registered outputs after edge N.
- Reset: when rst == 1 at a rising edge, out_valid, opcode_q, regid_q, immed_q, imm_sext, imm_zext and all cls_* are cleared to 0. rst has priority over in_valid.
- Reset asserted mid-stream discards the instruction captured at that edge. The first valid word after rst deasserts appears one cycle after its in_valid edge.
- in_valid held high on consecutive cycles gives full throughput: one decode per cycle with no stall or backpressure.

## Structure
- Shared package cpu_pkg holds:
  - Field widths and positions: OPCODE_W = 6, IMM_W = 9, INSTR_W = 16, OPC_MSB = 15, REGID_BIT = 9.
  - The opcode-class enum: CLS_ALU = 2'b00, CLS_MEM = 2'b01, CLS_BRANCH = 2'b10, CLS_SYS = 2'b11.
- Single flat module with no sub-modules. The field slicer is a continuous assignment; the pipeline register is one clocked process.

## Test plan
- instr = 16'h0000 -> opcode = 000000, regid = 0, immed = 000000000 combinationally. With in_valid, after one clk: imm_sext = 16'h0000, cls_alu = 1.
- instr = 16'hFFFF -> opcode = 111111, regid = 1, immed = 111111111. After clk: imm_sext = 16'hFFFF, imm_zext = 16'h01FF, cls_sys = 1.
- instr = 16'h8001 -> opcode = 100000, regid = 0, immed = 000000001. After clk: imm_sext = 16'h0001, cls_branch = 1.
- instr = 16'h06FF (opcode 000001, regid 1, immed 0FF) with in_valid, then instr = 16'h0100 with in_valid = 0 -> registered outputs hold immed_q = 9'h0FF and imm_sext = 16'h00FF; out_valid = 0 on the second cycle.
- Load 16'hFFFF, then assert rst with in_valid = 1 -> all registered outputs are 0 after that edge, while the combinational fields still track instr.
- Back-to-back stream of 16'h4123 then 16'h8001 with in_valid continuously high -> registered outputs update every cycle with one-cycle lag. cls_mem then cls_branch; regid_q = 0 then 0.
